// File: rtl/alu.sv
// 16-bit registered ALU for the execute stage: one-cycle result plus
// sign/zero/carry/parity/overflow flags for the branch logic.
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  op,
  input  logic [15:0] X,
  input  logic [15:0] Y,
  output logic [15:0] Z,
  output logic        S,
  output logic        ZR,
  output logic        CY,
  output logic        P,
  output logic        V
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_e;

  op_e         op_sel;
  logic [16:0] sum;
  logic [16:0] diff;
  logic [15:0] z_nxt;
  logic        cy_nxt;
  logic        v_nxt;

  assign op_sel = op_e'(op);
  assign sum    = {1'b0, X} + {1'b0, Y};
  // Bit 16 of the 17-bit difference is the unsigned borrow (X < Y).
  assign diff   = {1'b0, X} - {1'b0, Y};

  // NOTE: every output of an always_comb gets a default first so that no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    z_nxt  = '0;
    cy_nxt = 1'b0;
    v_nxt  = 1'b0;
    unique case (op_sel)
      OP_ADD: begin
        z_nxt  = sum[15:0];
        cy_nxt = sum[16];
        v_nxt  = (X[15] == Y[15]) && (sum[15] != X[15]);
      end
      OP_SUB: begin
        z_nxt  = diff[15:0];
        cy_nxt = diff[16];
        v_nxt  = (X[15] != Y[15]) && (diff[15] != X[15]);
      end
      OP_AND: z_nxt = X & Y;
      OP_OR:  z_nxt = X | Y;
      OP_XOR: z_nxt = X ^ Y;
      OP_NOT: z_nxt = ~X;
      OP_SHL: begin
        z_nxt  = {X[14:0], 1'b0};
        cy_nxt = X[15];
        v_nxt  = X[15] ^ X[14];
      end
      OP_SHR: begin
        z_nxt  = {1'b0, X[15:1]};
        cy_nxt = X[0];
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // Flags come from z_nxt, not from Z, so they track the same-cycle result;
  // during reset ZR and P are forced low even though Z is zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Z  <= '0;
      S  <= 1'b0;
      ZR <= 1'b0;
      CY <= 1'b0;
      P  <= 1'b0;
      V  <= 1'b0;
    end else begin
      Z  <= z_nxt;
      S  <= z_nxt[15];
      ZR <= (z_nxt == 16'h0000);
      CY <= cy_nxt;
      P  <= ~^z_nxt;
      V  <= v_nxt;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, reset sequences and
// randomized back-to-back operations against an arithmetic reference model.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  op;
  logic [15:0] X, Y;
  logic [15:0] Z;
  logic        S, ZR, CY, P, V;

  int checks   = 0;
  int failures = 0;

  alu dut (
    .clk(clk), .rst(rst), .op(op), .X(X), .Y(Y),
    .Z(Z), .S(S), .ZR(ZR), .CY(CY), .P(P), .V(V)
  );

  always #5 clk = ~clk;

  // Outputs packed as {Z, S, ZR, CY, P, V}.
  function automatic logic [20:0] outs();
    return {Z, S, ZR, CY, P, V};
  endfunction

  task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got Z=%h S%b ZR%b CY%b P%b V%b, want Z=%h S%b ZR%b CY%b P%b V%b",
               name, act[20:5], act[4], act[3], act[2], act[1], act[0],
               exp[20:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Reference model: plain integer arithmetic on unsigned and signed views.
  function automatic logic [20:0] model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int r;
    logic [15:0] z;
    logic cy = 1'b0;
    logic v  = 1'b0;
    case (o)
      3'd0: begin r = ua + ub; z = 16'(r); cy = (r > 65535);
                  v = (sa + sb > 32767) || (sa + sb < -32768); end
      3'd1: begin r = ua - ub; z = 16'(r); cy = (ua < ub);
                  v = (sa - sb > 32767) || (sa - sb < -32768); end
      3'd2: z = a & b;
      3'd3: z = a | b;
      3'd4: z = a ^ b;
      3'd5: z = ~a;
      3'd6: begin z = 16'(ua * 2); cy = (ua >= 32768);
                  v = (sa * 2 > 32767) || (sa * 2 < -32768); end
      default: begin z = 16'(ua / 2); cy = (ua % 2 == 1); end
    endcase
    return {z, z[15], (z == 16'h0000), cy, ($countones(z) % 2 == 0), v};
  endfunction

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [15:0] x;
    logic [15:0] y;
    logic [20:0] exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [20:0] prev;

    //           name          op      X         Y          Z        S    ZR   CY   P    V
    vecs[0] = '{"add_negneg", 3'b000, 16'h8fff, 16'h8000, {16'h0fff, 1'b0,1'b0,1'b1,1'b1,1'b1}};
    vecs[1] = '{"add_wrap0",  3'b000, 16'hfffe, 16'h0002, {16'h0000, 1'b0,1'b1,1'b1,1'b1,1'b0}};
    vecs[2] = '{"add_nocy",   3'b000, 16'hAAAA, 16'h5555, {16'hFFFF, 1'b1,1'b0,1'b0,1'b1,1'b0}};
    vecs[3] = '{"sub_borrow", 3'b001, 16'h0000, 16'h0001, {16'hFFFF, 1'b1,1'b0,1'b1,1'b1,1'b0}};
    vecs[4] = '{"sub_ovf",    3'b001, 16'h8000, 16'h0001, {16'h7FFF, 1'b0,1'b0,1'b0,1'b0,1'b1}};
    vecs[5] = '{"xor_zero",   3'b100, 16'h5A5A, 16'h5A5A, {16'h0000, 1'b0,1'b1,1'b0,1'b1,1'b0}};
    vecs[6] = '{"shl",        3'b110, 16'hC001, 16'h0000, {16'h8002, 1'b1,1'b0,1'b1,1'b1,1'b0}};
    vecs[7] = '{"shr",        3'b111, 16'h0003, 16'h0000, {16'h0001, 1'b0,1'b0,1'b1,1'b0,1'b0}};
    vecs[8] = '{"not",        3'b101, 16'h00FF, 16'h1234, {16'hFF00, 1'b1,1'b0,1'b0,1'b1,1'b0}};

    // Reset held with clocks running and live inputs.
    rst = 1'b1; op = 3'b000; X = 16'h1234; Y = 16'h0001;
    repeat (3) @(posedge clk);
    #1 check("reset_held", outs(), 21'd0);

    // First edge after release loads 0x1235 (six ones, so parity is even).
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1
    check("reset_release", outs(), {16'h1235, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});

    // Directed vectors on consecutive edges.
    foreach (vecs[i]) begin
      @(negedge clk);
      op = vecs[i].op; X = vecs[i].x; Y = vecs[i].y;
      @(posedge clk); #1
      check(vecs[i].name, outs(), vecs[i].exp);
      check({vecs[i].name, "_model"}, outs(), model(vecs[i].op, vecs[i].x, vecs[i].y));
    end

    // Asynchronous reset clears outputs between edges and discards in-flight op.
    @(negedge clk);
    op = 3'b000; X = 16'h7fff; Y = 16'h0001;
    #2 rst = 1'b1;
    #1 check("async_reset", outs(), 21'd0);
    @(posedge clk); #1
    check("reset_discard", outs(), 21'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1
    check("after_midreset", outs(), model(3'b000, 16'h7fff, 16'h0001));

    // Randomized back-to-back ops: new inputs every cycle, outputs must hold
    // the previous result until the next edge and then show the new one.
    prev = model(3'b000, 16'h7fff, 16'h0001);
    for (int n = 0; n < 400; n++) begin
      logic [20:0] exp;
      @(negedge clk);
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       begin X = 16'h8000; Y = 16'($urandom); end
        1:       begin X = 16'hffff; Y = 16'($urandom_range(0, 2)); end
        default: begin X = 16'($urandom); Y = 16'($urandom); end
      endcase
      exp = model(op, X, Y);
      #1 check("hold", outs(), prev);
      @(posedge clk); #1
      check("random", outs(), exp);
      prev = exp;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
